pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Purpose:
//   Sequences the board PLL out of reset and turns its lock output into a
//   clean, lock-qualified system reset for the VDP core.
//   - Pulses the PLL reset for PLL_RST_CYCLES cycles.
//   - Waits up to TIMEOUT cycles for lock, re-pulsing the PLL reset if lock
//     never arrives.
//   - Requires LOCK_FILT consecutive synchronised lock-high cycles before
//     accepting lock.
//   - Holds sys_reset_n low for HOLD_CYCLES more cycles, then releases it.
//   - Any synchronised lock low while locked restarts the whole sequence.
//   - Counts relock events (lock loss in S_RUN and lock timeouts), saturating
//     at 255.
//
// Handshake / timing:
//   There is no valid/ready handshake. force_relock is a single-cycle level
//   request sampled on each clk edge. It takes priority over every lock-driven
//   transition in the same cycle. All outputs are registered and change on
//   the same edge as the state register.
//
// Ports:
//   clk          in   27 MHz board clock (also the PLL reference clock)
//   reset_n      in   synchronous, active-low reset
//   pll_lock     in   PLL lock output, asynchronous to clk
//   force_relock in   single-cycle request to restart the PLL
//   pll_reset    out  PLL reset input, active high
//   sys_reset_n  out  active-low system reset (downstream resynchronises it)
//   locked       out  high while in S_HOLD or S_RUN
//   relock_cnt   out  saturating count of relock events
//   dbg_state    out  current FSM state encoding, for debug and checkers
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int LOCK_FILT      = 1024,
    parameter int HOLD_CYCLES    = 256,
    parameter int TIMEOUT        = 65535,
    parameter int PLL_RST_CYCLES = 16,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic       locked,
    output logic [7:0] relock_cnt,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_FILT   = 3'd2,
        S_HOLD   = 3'd3,
        S_RUN    = 3'd4
    } state_e;

    // Terminal counts. cnt is 0 on the first edge spent in a state, so a state
    // lasting N cycles leaves when cnt equals N-1.
    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       relock_q, relock_d;
    logic             relock_inc;

    // Two-flop synchroniser for the asynchronous lock signal.
    logic             sync1_q;
    logic             lock_s_q;

    // Registered outputs.
    logic             pll_reset_q, pll_reset_d;
    logic             sys_reset_n_q, sys_reset_n_d;
    logic             locked_q, locked_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        relock_inc = 1'b0;

        if (force_relock) begin
            // Forced restart wins over everything, including a lock drop or a
            // timeout in the same cycle, and is not counted as a relock event.
            state_d = S_PLLRST;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_PLLRST: begin
                    if (cnt_q == PLLRST_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
                S_WAIT: begin
                    if (lock_s_q) begin
                        state_d = S_FILT;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d    = S_PLLRST;
                        cnt_d      = '0;
                        relock_inc = 1'b1;
                    end
                end
                S_FILT: begin
                    // A dropout only restarts filtering; the timeout window
                    // restarts from zero as well.
                    if (!lock_s_q) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == FILT_LAST) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end
                S_HOLD: begin
                    // Lock lost before the core ever ran: restart, not counted.
                    if (!lock_s_q) begin
                        state_d = S_PLLRST;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                    if (!lock_s_q) begin
                        state_d    = S_PLLRST;
                        relock_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = S_PLLRST;
                    cnt_d   = '0;
                end
            endcase
        end

        relock_d = relock_q;
        if (relock_inc && (relock_q != 8'hFF)) begin
            relock_d = relock_q + 8'd1;
        end

        // Outputs are a registered decode of the next state so that they
        // change on the same edge as the state register.
        pll_reset_d   = (state_d == S_PLLRST);
        sys_reset_n_d = (state_d == S_RUN);
        locked_d      = (state_d == S_HOLD) || (state_d == S_RUN);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_PLLRST;
            cnt_q         <= '0;
            sync1_q       <= 1'b0;
            lock_s_q      <= 1'b0;
            relock_q      <= 8'd0;
            pll_reset_q   <= 1'b1;
            sys_reset_n_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync1_q       <= pll_lock;
            lock_s_q      <= sync1_q;
            relock_q      <= relock_d;
            pll_reset_q   <= pll_reset_d;
            sys_reset_n_q <= sys_reset_n_d;
            locked_q      <= locked_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign sys_reset_n = sys_reset_n_q;
    assign locked      = locked_q;
    assign relock_cnt  = relock_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed bench for pll_lock_sequencer with LOCK_FILT=8, HOLD_CYCLES=4,
// TIMEOUT=32, PLL_RST_CYCLES=4. Edge numbering inside each task is relative
// to an anchor edge named in that task. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
// Observed/expected vectors are packed as {pll_reset, locked, sys_reset_n,
// relock_cnt[7:0]}.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       locked;
    logic [7:0] relock_cnt;
    logic [2:0] dbg_state;

    int n_vec;
    int n_err;

    pll_lock_sequencer #(
        .LOCK_FILT      (8),
        .HOLD_CYCLES    (4),
        .TIMEOUT        (32),
        .PLL_RST_CYCLES (4),
        .CNT_W          (17)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_lock     (pll_lock),
        .force_relock (force_relock),
        .pll_reset    (pll_reset),
        .sys_reset_n  (sys_reset_n),
        .locked       (locked),
        .relock_cnt   (relock_cnt),
        .dbg_state    (dbg_state)
    );

    // ---------------------------------------------------------------------
    // Clock
    // ---------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge, then settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] pack_obs();
        return {pll_reset, locked, sys_reset_n, relock_cnt};
    endfunction

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        logic [10:0] obs;
        logic [10:0] exp_v;
        reset_n      = 1'b0;
        pll_lock     = 1'b1;
        force_relock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            obs   = pack_obs();
            exp_v = {1'b1, 1'b0, 1'b0, 8'd0};
            n_vec++;
            if (obs !== exp_v) begin
                $display("FAIL reset cycle %0d: got %h want %h", i, obs, exp_v);
                n_err++;
            end
        end
    endtask

    // Edge 0 still samples reset_n low; reset_n is released right after it.
    // pll_lock is first sampled high at edge 10.
    task automatic test_cold_start();
        logic [10:0] obs;
        logic [10:0] exp_v;
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        step();
        obs   = pack_obs();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== exp_v) begin
            $display("FAIL cold_start edge 0: got %h want %h", obs, exp_v);
            n_err++;
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            pll_lock = (e >= 10);
            step();
            obs   = pack_obs();
            exp_v = {(e <= 3), (e >= 20), (e >= 24), 8'd0};
            n_vec++;
            if (obs !== exp_v) begin
                $display("FAIL cold_start edge %0d: got %h want %h", e, obs, exp_v);
                n_err++;
            end
        end
    endtask

    // Starts in S_RUN. pll_lock sampled low at edge k=0 only.
    task automatic test_lock_loss();
        logic [10:0] obs;
        logic [10:0] exp_v;
        for (int k = 0; k <= 22; k++) begin
            pll_lock = (k != 0);
            step();
            obs   = pack_obs();
            exp_v = {(k >= 2 && k <= 5), (k < 2 || k >= 15), (k < 2 || k >= 19),
                     (k >= 2) ? 8'd1 : 8'd0};
            n_vec++;
            if (obs !== exp_v) begin
                $display("FAIL lock_loss edge %0d: got %h want %h", k, obs, exp_v);
                n_err++;
            end
        end
    endtask

    // Starts in S_RUN with relock_cnt=1. force_relock sampled at k=0.
    task automatic test_force_relock();
        logic [10:0] obs;
        logic [10:0] exp_v;
        pll_lock = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            force_relock = (k == 0);
            step();
            obs   = pack_obs();
            exp_v = {(k <= 3), (k >= 13), (k >= 17), 8'd1};
            n_vec++;
            if (obs !== exp_v) begin
                $display("FAIL force_relock edge %0d: got %h want %h", k, obs, exp_v);
                n_err++;
            end
        end
        force_relock = 1'b0;
    endtask

    // Second force arrives while already pulsing: the pulse restarts.
    task automatic test_back_to_back();
        logic [10:0] obs;
        logic [10:0] exp_v;
        pll_lock = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            force_relock = (k == 0 || k == 2);
            step();
            obs   = pack_obs();
            exp_v = {(k <= 5), (k >= 15), (k >= 19), 8'd1};
            n_vec++;
            if (obs !== exp_v) begin
                $display("FAIL back_to_back edge %0d: got %h want %h", k, obs, exp_v);
                n_err++;
            end
        end
        force_relock = 1'b0;
    endtask

    // Lock high for edges 6..10, low at 11, high from 12 onward.
    task automatic test_filter();
        logic [10:0] obs;
        logic [10:0] exp_v;
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            pll_lock = (e >= 6 && e <= 10) || (e >= 12);
            step();
            obs   = pack_obs();
            exp_v = {(e <= 3), (e >= 22), (e >= 26), 8'd0};
            n_vec++;
            if (obs !== exp_v) begin
                $display("FAIL filter edge %0d: got %h want %h", e, obs, exp_v);
                n_err++;
            end
        end
    endtask

    // No lock: pulse at 36, 72, 108 ...
    task automatic test_timeout();
        logic [10:0] obs;
        logic [10:0] exp_v;
        logic        exp_pr;
        logic [7:0]  exp_rc;
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 120; e++) begin
            step();
            if (e <= 3) begin
                exp_pr = 1'b1;
                exp_rc = 8'd0;
            end else if (e < 36) begin
                exp_pr = 1'b0;
                exp_rc = 8'd0;
            end else begin
                exp_pr = (((e - 36) % 36) < 4);
                exp_rc = 8'((e - 36) / 36 + 1);
            end
            obs   = pack_obs();
            exp_v = {exp_pr, 1'b0, 1'b0, exp_rc};
            n_vec++;
            if (obs !== exp_v) begin
                $display("FAIL timeout edge %0d: got %h want %h", e, obs, exp_v);
                n_err++;
            end
        end
    endtask

    task automatic test_saturation_and_reset();
        logic [7:0]  exp_rc;
        logic [10:0] obs;
        logic [10:0] exp_v;
        int          n_to;
        int          waited;
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 300 * 36; e++) begin
            step();
            if ((e % 36) == 0) begin
                n_to   = e / 36;
                exp_rc = (n_to > 255) ? 8'd255 : 8'(n_to);
                n_vec++;
                if (relock_cnt !== exp_rc) begin
                    $display("FAIL saturation after %0d timeouts: got %0d want %0d",
                             n_to, relock_cnt, exp_rc);
                    n_err++;
                end
            end
        end
        // Bring the FSM into S_HOLD, then reset in the middle of it.
        pll_lock = 1'b1;
        waited   = 0;
        while (locked !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        n_vec++;
        if (locked !== 1'b1) begin
            $display("FAIL hold_wait: locked got %b want 1 within 200 cycles", locked);
            n_err++;
        end
        step();
        obs   = pack_obs();
        exp_v = {1'b0, 1'b1, 1'b0, 8'd255};
        n_vec++;
        if (obs !== exp_v) begin
            $display("FAIL mid_hold: got %h want %h", obs, exp_v);
            n_err++;
        end
        reset_n = 1'b0;
        step();
        obs   = pack_obs();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== exp_v) begin
            $display("FAIL reset_in_hold: got %h want %h", obs, exp_v);
            n_err++;
        end
        reset_n = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Sequence and report
    // ---------------------------------------------------------------------
    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        pll_lock     = 1'b0;
        force_relock = 1'b0;
        test_reset();
        test_cold_start();
        test_lock_loss();
        test_force_relock();
        test_back_to_back();
        test_filter();
        test_timeout();
        test_saturation_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
